// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit order,
// the blank pattern and the hex-to-segment table (all active-low).
package sevenseg_pkg;

  // Bit positions inside a 7-bit segment vector {g,f,e,d,c,b,a}
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the active-low pattern for hex digit n (entry 0 is rightmost)
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sevenseg_hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode display scanner with per-frame input snapshot,
// per-slot guard interval, leading-zero blanking and decimal points.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NDIG    = 4,
  parameter int REFRESH = 100000,
  parameter int GUARD   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp,
  input  logic              blank_lz,
  output logic [NDIG-1:0]   an,
  output logic [6:0]        seg,
  output logic              dp_n,
  output logic              frame_done
);

  localparam int IDX_W = min1_clog2(NDIG);
  localparam int CNT_W = min1_clog2(REFRESH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH - 1);

  logic              run_q, run_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4*NDIG-1:0] snap_digits_q, snap_digits_d;
  logic [NDIG-1:0]   snap_dp_q, snap_dp_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;
  logic              frame_done_q, frame_done_d;

  logic              frame_wrap;
  logic [3:0]        cur_nibble;
  logic [6:0]        dec_seg;
  logic [NDIG-1:0]   blank_vec;
  logic              cur_blank;
  logic              drive;

  // run_q is low for the reset cycles so the first active edge lands on (0, 0)
  always_comb begin
    frame_wrap = run_q && (idx_q == LAST_IDX) && (cnt_q == LAST_CNT);
    run_d      = 1'b1;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CNT_W'(1);
    if (!run_q) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    if (!rstn || frame_wrap) begin
      snap_digits_d = digits;
      snap_dp_d     = dp;
    end
  end

  // A digit is blanked when it and every more significant nibble are zero
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zero_above   = zero_above && (snap_digits_d[4*i +: 4] == 4'h0);
      blank_vec[i] = blank_lz && zero_above;
    end
  end

  assign cur_nibble = snap_digits_d[{idx_d, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .hex (cur_nibble),
    .seg (dec_seg)
  );

  // Outputs are derived from next-state values so they line up with (idx, cnt)
  always_comb begin
    cur_blank    = blank_vec[idx_d];
    drive        = (int'(cnt_d) >= GUARD);
    an_d         = '1;
    if (drive && !cur_blank) begin
      an_d = ~(NDIG'(1) << idx_d);
    end
    seg_d        = cur_blank ? SEG_OFF : dec_seg;
    dp_n_d       = cur_blank ? 1'b1 : ~snap_dp_d[idx_d];
    frame_done_d = (idx_d == LAST_IDX) && (cnt_d == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_q        <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      run_q        <= run_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    snap_digits_q <= snap_digits_d;
    snap_dp_q     <= snap_dp_d;
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: directed steps plus random traffic, checked every
// cycle against a frame-position model of the display.
module tb_sevenseg_scan;

  localparam int NDIG    = 4;
  localparam int REFRESH = 8;
  localparam int GUARD   = 2;
  localparam int FRAME   = NDIG * REFRESH;

  localparam logic [6:0] SEGS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  bit          m_rst = 1'b1;
  int          m_pos = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp  = '0;
  bit          m_blz = 1'b0;

  always #5 clk = ~clk;

  sevenseg_scan #(
    .NDIG    (NDIG),
    .REFRESH (REFRESH),
    .GUARD   (GUARD)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .digits     (digits),
    .dp         (dp),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  task automatic applyStimulus(input logic r, input logic [15:0] d,
                               input logic [3:0] p, input logic b);
    rstn     = r;
    digits   = d;
    dp       = p;
    blank_lz = b;
  endtask

  task automatic expectEq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h pos=%0d", tag, act, exp, m_pos);
    end
  endtask

  task automatic checkOutput();
    int         slot, c;
    logic [15:0] upper;
    bit         blanked;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dpn, exp_fd;
    if (m_rst) begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dpn = 1'b1;
      exp_fd  = 1'b0;
    end else begin
      slot    = m_pos / REFRESH;
      c       = m_pos % REFRESH;
      upper   = m_dig >> (4 * slot);
      blanked = m_blz && (slot >= 1) && (upper == 16'h0);
      exp_an  = (blanked || c < GUARD) ? 4'hF : 4'(~(4'b0001 << slot));
      exp_seg = blanked ? 7'h7F : SEGS[upper[3:0]];
      exp_dpn = blanked ? 1'b1 : ~m_dp[slot];
      exp_fd  = (m_pos == FRAME - 1);
    end
    expectEq("an", 16'(an), 16'(exp_an));
    expectEq("seg", 16'(seg), 16'(exp_seg));
    expectEq("dp_n", 16'(dp_n), 16'(exp_dpn));
    expectEq("frame_done", 16'(frame_done), 16'(exp_fd));
  endtask

  // One clock: advance the model using the inputs seen at the edge, then check
  task automatic tick();
    logic        r;
    logic [15:0] d;
    logic [3:0]  p;
    logic        b;
    r = rstn;
    d = digits;
    p = dp;
    b = blank_lz;
    @(posedge clk);
    if (!r) begin
      m_rst = 1'b1;
      m_pos = 0;
      m_dig = d;
      m_dp  = p;
    end else if (m_rst) begin
      m_rst = 1'b0;
      m_pos = 0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0;
      m_dig = d;
      m_dp  = p;
    end else begin
      m_pos++;
    end
    m_blz = b;
    #1;
    checkOutput();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    applyStimulus(1'b0, 16'h1234, 4'h0, 1'b0);
    runCycles(3);
    expectEq("reset_an", 16'(an), 16'h000F);
    expectEq("reset_seg", 16'(seg), 16'h007F);

    applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0);
    tick();
    expectEq("first_an", 16'(an), 16'h000F);
    expectEq("first_seg", 16'(seg), 16'h0019);
    runCycles(2);
    expectEq("drive_an", 16'(an), 16'h000E);
    runCycles(9);
    applyStimulus(1'b1, 16'hABCD, 4'h0, 1'b0);
    runCycles(20);
    tick();
    expectEq("new_frame_seg", 16'(seg), 16'h0021);
    runCycles(70);

    applyStimulus(1'b1, 16'h0050, 4'h0, 1'b1);
    runCycles(64);
    applyStimulus(1'b1, 16'h0000, 4'h0, 1'b1);
    runCycles(64);

    applyStimulus(1'b1, 16'h9876, 4'b0010, 1'b0);
    runCycles(64);

    while (m_pos != 12) tick();
    tick();
    applyStimulus(1'b0, 16'h1234, 4'h0, 1'b0);
    tick();
    expectEq("midreset_fd", 16'(frame_done), 16'h0000);
    applyStimulus(1'b1, 16'h1234, 4'h0, 1'b0);
    runCycles(40);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)
        digits = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 29) == 0) blank_lz = 1'($urandom);
      rstn = ($urandom_range(0, 199) != 0);
      tick();
    end
    rstn = 1'b1;
    runCycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
